// File: rtl/riscv_pkg.sv
// Shared pipeline definitions: data width, memory-arbiter state encoding, load/store opcodes.
package riscv_pkg;

    localparam int XLEN = 32;

    localparam logic [6:0] OPC_LW = 7'b0000011;
    localparam logic [6:0] OPC_SW = 7'b0100011;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BUSY_I = 2'd1,
        BUSY_D = 2'd2
    } arb_state_t;

    function automatic logic is_mem_opcode(input logic [6:0] opc);
        return (opc == OPC_LW) || (opc == OPC_SW);
    endfunction

endpackage

// File: rtl/mem_arb_perf_counters.sv
// Performance counters for mem_port_arbiter: data grants and IF stall cycles, free-running 32-bit wrap.
module mem_arb_perf_counters (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        d_gnt,
    input  logic        if_req,
    input  logic        if_gnt,
    output logic [31:0] perf_d_cnt,
    output logic [31:0] perf_if_stall
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_d_cnt    <= '0;
            perf_if_stall <= '0;
        end else begin
            if (d_gnt) begin
                perf_d_cnt <= perf_d_cnt + 32'd1;
            end
            // a stall cycle is any cycle where IF is asking and is not being granted
            if (if_req && !if_gnt) begin
                perf_if_stall <= perf_if_stall + 32'd1;
            end
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Single-port unified memory arbiter between the IF and MEM pipeline stages, one transaction in flight.
// Optional performance counters are built when MEM_ARB_PERF_CNT_EN is defined.
//
// state  | meaning
// IDLE   | no transaction; arbitrate between if_req and d_req
// BUSY_I | instruction fetch issued, waiting for mem_ack
// BUSY_D | load/store issued, waiting for mem_ack
module mem_port_arbiter
    import riscv_pkg::*;
#(
    parameter int XLEN         = riscv_pkg::XLEN,
    parameter int STARVE_LIMIT = 3
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            if_req,
    input  logic [XLEN-1:0] if_addr,
    output logic            if_gnt,
    output logic            if_rvalid,
    output logic [XLEN-1:0] if_rdata,
    input  logic            d_req,
    input  logic            d_we,
    input  logic [XLEN-1:0] d_addr,
    input  logic [XLEN-1:0] d_wdata,
    output logic            d_gnt,
    output logic            d_rvalid,
    output logic [XLEN-1:0] d_rdata,
    output logic            mem_req,
    output logic            mem_we,
    output logic [XLEN-1:0] mem_addr,
    output logic [XLEN-1:0] mem_wdata,
    input  logic            mem_ack,
    input  logic [XLEN-1:0] mem_rdata,
    output logic [31:0]     perf_d_cnt,
    output logic [31:0]     perf_if_stall
);

    localparam logic [3:0] STARVE_MAX = 4'(STARVE_LIMIT);

    arb_state_t state;
    logic [3:0] starve_cnt;
    logic       pick_i;
    logic       pick_d;

    // data wins conflicts until IF has lost STARVE_LIMIT times in a row
    always_comb begin
        pick_i = if_req && (!d_req || (starve_cnt == STARVE_MAX));
        pick_d = d_req && !pick_i;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            starve_cnt <= '0;
            if_gnt     <= 1'b0;
            d_gnt      <= 1'b0;
            if_rvalid  <= 1'b0;
            d_rvalid   <= 1'b0;
            if_rdata   <= '0;
            d_rdata    <= '0;
            mem_req    <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
        end else begin
            if_gnt    <= 1'b0;
            d_gnt     <= 1'b0;
            if_rvalid <= 1'b0;
            d_rvalid  <= 1'b0;
            case (state)
                IDLE: begin
                    if (pick_d) begin
                        state     <= BUSY_D;
                        d_gnt     <= 1'b1;
                        mem_req   <= 1'b1;
                        mem_we    <= d_we;
                        mem_addr  <= d_addr;
                        mem_wdata <= d_wdata;
                        if (if_req && (starve_cnt != STARVE_MAX)) begin
                            starve_cnt <= starve_cnt + 4'd1;
                        end
                    end else if (pick_i) begin
                        state      <= BUSY_I;
                        if_gnt     <= 1'b1;
                        mem_req    <= 1'b1;
                        mem_we     <= 1'b0;
                        mem_addr   <= if_addr;
                        mem_wdata  <= '0;
                        starve_cnt <= '0;
                    end
                end
                BUSY_I: begin
                    if (mem_ack) begin
                        state     <= IDLE;
                        mem_req   <= 1'b0;
                        if_rvalid <= 1'b1;
                        if_rdata  <= mem_rdata;
                    end
                end
                BUSY_D: begin
                    if (mem_ack) begin
                        state    <= IDLE;
                        mem_req  <= 1'b0;
                        d_rvalid <= 1'b1;
                        d_rdata  <= mem_we ? '0 : mem_rdata;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

`ifdef MEM_ARB_PERF_CNT_EN
    mem_arb_perf_counters u_perf (
        .clk           (clk),
        .rst_n         (rst_n),
        .d_gnt         (d_gnt),
        .if_req        (if_req),
        .if_gnt        (if_gnt),
        .perf_d_cnt    (perf_d_cnt),
        .perf_if_stall (perf_if_stall)
    );
`else
    assign perf_d_cnt    = '0;
    assign perf_if_stall = '0;
`endif

endmodule
